// File: rtl/body_integrator.sv
// body_integrator: one semi-implicit Euler timestep over N bodies held in a
// shared 80-bit BRAM. For each body it reads the body word and its force word,
// then updates velocity, then position (using the new velocity), with 16-bit
// saturation, and writes the body back in place. Six cycles per body.
module body_integrator #(
  parameter int N          = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int FORCE_BASE = 400,
  parameter int DT_SHIFT   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_rd_en,
  output logic                  bram_wr_en,
  output logic [79:0]           bram_wr_data,
  input  logic [79:0]           bram_rd_data
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_BODY, CAP_BODY, RD_FORCE, CAP_FORCE, UPDATE, WRITE, DONE
  } state_t;

  state_t state_reg, state_next;

  logic [IW-1:0]      idx_reg;
  logic [79:0]        body_reg;
  logic signed [31:0] fx_reg, fy_reg;
  logic signed [15:0] x_new_reg, y_new_reg, vx_new_reg, vy_new_reg;

  // Upper 16 bits of a force word are padding and carry no information.
  logic unused_force_hi;
  assign unused_force_hi = ^bram_rd_data[79:64];

  // Clamp a sign-extended sum into the signed 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767)       return 16'sh7fff;
    else if (v < -33'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  logic signed [15:0] x_cur, y_cur, vx_cur, vy_cur;
  logic signed [31:0] dvx, dvy;
  logic signed [32:0] vx_sum, vy_sum;
  logic signed [15:0] vx_next, vy_next, vx_step, vy_step;
  logic signed [16:0] x_sum, y_sum;
  logic signed [15:0] x_next, y_next;

  assign x_cur  = body_reg[79:64];
  assign y_cur  = body_reg[63:48];
  assign vx_cur = body_reg[47:32];
  assign vy_cur = body_reg[31:16];

  // Velocity first: v' = sat(v + (a >>> shift)), widened so the sum never wraps.
  assign dvx     = fx_reg >>> DT_SHIFT;
  assign dvy     = fy_reg >>> DT_SHIFT;
  assign vx_sum  = {{17{vx_cur[15]}}, vx_cur} + {dvx[31], dvx};
  assign vy_sum  = {{17{vy_cur[15]}}, vy_cur} + {dvy[31], dvy};
  assign vx_next = sat16(vx_sum);
  assign vy_next = sat16(vy_sum);

  // Position uses the already-updated velocity (semi-implicit Euler).
  assign vx_step = vx_next >>> DT_SHIFT;
  assign vy_step = vy_next >>> DT_SHIFT;
  assign x_sum   = {x_cur[15], x_cur} + {vx_step[15], vx_step};
  assign y_sum   = {y_cur[15], y_cur} + {vy_step[15], vy_step};
  assign x_next  = sat16({{16{x_sum[16]}}, x_sum});
  assign y_next  = sat16({{16{y_sum[16]}}, y_sum});

  // State register and datapath captures for the current phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      body_reg   <= '0;
      fx_reg     <= '0;
      fy_reg     <= '0;
      x_new_reg  <= '0;
      y_new_reg  <= '0;
      vx_new_reg <= '0;
      vy_new_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE, DONE: if (start) idx_reg <= '0;
        CAP_BODY:   body_reg <= bram_rd_data;
        CAP_FORCE: begin
          fx_reg <= bram_rd_data[63:32];
          fy_reg <= bram_rd_data[31:0];
        end
        UPDATE: begin
          x_new_reg  <= x_next;
          y_new_reg  <= y_next;
          vx_new_reg <= vx_next;
          vy_new_reg <= vy_next;
        end
        WRITE:      idx_reg <= idx_reg + 1'b1;
        default:    ;
      endcase
    end
  end

  // Next-state sequencing and BRAM strobes, decoded from the current state.
  always_comb begin
    state_next   = state_reg;
    bram_addr    = '0;
    bram_rd_en   = 1'b0;
    bram_wr_en   = 1'b0;
    bram_wr_data = '0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = RD_BODY;
      end
      RD_BODY: begin
        bram_rd_en = 1'b1;
        bram_addr  = ADDR_WIDTH'(idx_reg);
        state_next = CAP_BODY;
      end
      CAP_BODY:  state_next = RD_FORCE;
      RD_FORCE: begin
        bram_rd_en = 1'b1;
        bram_addr  = ADDR_WIDTH'(FORCE_BASE) + ADDR_WIDTH'(idx_reg);
        state_next = CAP_FORCE;
      end
      CAP_FORCE: state_next = UPDATE;
      UPDATE:    state_next = WRITE;
      WRITE: begin
        // Never write while reset is asserted, even if the state says WRITE.
        bram_wr_en   = !reset;
        bram_addr    = ADDR_WIDTH'(idx_reg);
        bram_wr_data = {x_new_reg, y_new_reg, vx_new_reg, vy_new_reg, body_reg[15:0]};
        state_next   = (idx_reg == IW'(N - 1)) ? DONE : RD_BODY;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_next = RD_BODY;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_body_integrator.sv
// Testbench for body_integrator: two instances (N=1 and N=4) each attached to
// a behavioural BRAM. Results are compared against an arithmetic reference
// model of the Euler step plus the documented cycle timing.
module tb_body_integrator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start   [2];
  logic        busy    [2];
  logic        done    [2];
  logic        rd_en   [2];
  logic        wr_en   [2];
  logic [15:0] addr    [2];
  logic [79:0] wr_data [2];
  logic [79:0] rd_data [2];

  logic [79:0] mem [2][512];
  logic        bd_we;
  int          bd_w;
  int          bd_a;
  logic [79:0] bd_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  body_integrator #(.N(1), .ADDR_WIDTH(16), .FORCE_BASE(400), .DT_SHIFT(6)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .bram_addr(addr[0]), .bram_rd_en(rd_en[0]), .bram_wr_en(wr_en[0]),
    .bram_wr_data(wr_data[0]), .bram_rd_data(rd_data[0])
  );

  body_integrator #(.N(4), .ADDR_WIDTH(16), .FORCE_BASE(400), .DT_SHIFT(6)) u_dut4 (
    .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .bram_addr(addr[1]), .bram_rd_en(rd_en[1]), .bram_wr_en(wr_en[1]),
    .bram_wr_data(wr_data[1]), .bram_rd_data(rd_data[1])
  );

  // Behavioural BRAMs with one-cycle read latency, plus a backdoor write port.
  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (rd_en[w]) rd_data[w] <= mem[w][addr[w][8:0]];
      if (wr_en[w]) mem[w][addr[w][8:0]] <= wr_data[w];
    end
    if (bd_we) mem[bd_w][bd_a] <= bd_d;
  end

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int w, input int a, input logic [79:0] d);
    bd_we = 1'b1; bd_w = w; bd_a = a; bd_d = d;
    tick;
    bd_we = 1'b0;
  endtask

  function automatic logic [79:0] mk_body(input int x, input int y, input int vx, input int vy, input int m);
    return {x[15:0], y[15:0], vx[15:0], vy[15:0], m[15:0]};
  endfunction

  function automatic logic [79:0] mk_force(input int fx, input int fy);
    return {16'd0, fx[31:0], fy[31:0]};
  endfunction

  // Division rounding toward negative infinity (what dt = 1/64 means here).
  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference Euler step: v' = clamp(v + a*dt), p' = clamp(p + v'*dt).
  function automatic logic [79:0] model_step(input logic [79:0] b, input logic [79:0] f);
    longint x, y, vx, vy, fx, fy, vxn, vyn, xn, yn;
    logic [15:0] xo, yo, vxo, vyo;
    x  = longint'($signed(b[79:64]));
    y  = longint'($signed(b[63:48]));
    vx = longint'($signed(b[47:32]));
    vy = longint'($signed(b[31:16]));
    fx = longint'($signed(f[63:32]));
    fy = longint'($signed(f[31:0]));
    vxn = clamp16(vx + floor_div(fx, 64));
    vyn = clamp16(vy + floor_div(fy, 64));
    xn  = clamp16(x + floor_div(vxn, 64));
    yn  = clamp16(y + floor_div(vyn, 64));
    xo = 16'(xn); yo = 16'(yn); vxo = 16'(vxn); vyo = 16'(vyn);
    return {xo, yo, vxo, vyo, b[15:0]};
  endfunction

  function automatic logic [79:0] rand_body();
    return {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  function automatic logic [79:0] rand_force();
    int fx, fy;
    if ($urandom_range(0, 3) == 0) begin
      fx = int'($urandom);
      fy = int'($urandom);
    end else begin
      fx = int'($urandom_range(0, 8000)) - 4000;
      fy = int'($urandom_range(0, 8000)) - 4000;
    end
    return mk_force(fx, fy);
  endfunction

  task automatic load_random(input int w, input int n);
    for (int i = 0; i < n; i++) begin
      poke(w, i, rand_body());
      poke(w, 400 + i, rand_force());
    end
  endtask

  // One full pass: start in cycle 0, observe every cycle, then check the
  // access order, write timing, done timing and the resulting memory.
  task automatic run_pass(input int w, input int n, input int busy_start);
    logic [79:0] exp_body [4];
    logic [79:0] force_copy [4];
    int rd_q[$];
    int wr_addr_q[$];
    int wr_cyc_q[$];
    int done_cyc;
    int late;
    done_cyc = -1;
    late = 0;
    for (int i = 0; i < n; i++) begin
      exp_body[i]   = model_step(mem[w][i], mem[w][400 + i]);
      force_copy[i] = mem[w][400 + i];
    end
    start[w] = 1'b1;
    for (int c = 1; c <= 6 * n + 40; c++) begin
      tick;
      if (c == 1) begin
        start[w] = 1'b0;
        check_val("first_rd", {busy[w], rd_en[w], addr[w]}, {1'b1, 1'b1, 16'd0});
      end
      if (c == busy_start) start[w] = 1'b1;
      else if (c == busy_start + 1) start[w] = 1'b0;
      if (done[w] && done_cyc < 0) begin
        done_cyc = c;
        check_val("done_flags", {busy[w], done[w]}, 2'b01);
      end
      if (done_cyc >= 0) begin
        if (rd_en[w] || wr_en[w]) late++;
      end else begin
        if (rd_en[w]) rd_q.push_back(int'(addr[w]));
        if (wr_en[w]) begin
          wr_addr_q.push_back(int'(addr[w]));
          wr_cyc_q.push_back(c);
        end
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    check_val("done_cyc", 80'(done_cyc), 80'(6 * n + 1));
    check_val("late_access", 80'(late), 80'd0);
    check_val("rd_count", 80'(rd_q.size()), 80'(2 * n));
    for (int k = 0; k < rd_q.size() && k < 2 * n; k++)
      check_val("rd_addr", 80'(rd_q[k]), 80'((k % 2 == 1) ? 400 + k / 2 : k / 2));
    check_val("wr_count", 80'(wr_addr_q.size()), 80'(n));
    for (int k = 0; k < wr_addr_q.size() && k < n; k++) begin
      check_val("wr_addr", 80'(wr_addr_q[k]), 80'(k));
      check_val("wr_cyc", 80'(wr_cyc_q[k]), 80'(6 * (k + 1)));
    end
    for (int i = 0; i < n; i++) begin
      check_val("body", mem[w][i], exp_body[i]);
      check_val("force_kept", mem[w][400 + i], force_copy[i]);
    end
    $display("pass dut=%0d n=%0d done_cyc=%0d reads=%0d writes=%0d", w, n, done_cyc,
             rd_q.size(), wr_addr_q.size());
  endtask

  // Directed plus random passes on both instances, then a mid-WRITE reset.
  initial begin
    logic [79:0] exp0, exp1, orig2, orig3;
    int bx;
    reset = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    bd_we = 1'b0; bd_w = 0; bd_a = 0; bd_d = '0;
    tick; tick;
    reset = 1'b0;
    for (int w = 0; w < 2; w++)
      check_val("rst_outs", {busy[w], done[w], rd_en[w], wr_en[w], addr[w], wr_data[w]}, '0);

    // N=1: basic step.
    poke(0, 0, mk_body(100, -50, 64, -128, 7));
    poke(0, 400, mk_force(640, -64));
    run_pass(0, 1, -1);
    check_val("basic_const", mem[0][0], mk_body(101, -53, 74, -129, 7));

    // N=1: positive saturation, restarted from DONE.
    poke(0, 0, mk_body(32760, 0, 32700, 0, 3));
    poke(0, 400, mk_force(6400, 0));
    run_pass(0, 1, -1);
    check_val("sat_pos_const", mem[0][0], mk_body(32767, 0, 32767, 0, 3));

    // N=1: negative saturation with the most negative force.
    poke(0, 0, mk_body(-32768, 0, -32768, 0, 9));
    poke(0, 400, mk_force(int'(32'h8000_0000), 0));
    run_pass(0, 1, -1);
    check_val("sat_neg_const", mem[0][0], mk_body(-32768, 0, -32768, 0, 9));

    // N=1: zero force, vx=63 moves nothing after the shift.
    bx = int'($urandom_range(0, 20000)) - 10000;
    poke(0, 0, mk_body(bx, 5, 63, 0, 1));
    poke(0, 400, mk_force(0, 0));
    run_pass(0, 1, -1);
    check_val("zero_force", mem[0][0], mk_body(bx, 5, 63, 0, 1));

    for (int r = 0; r < 3; r++) begin
      load_random(0, 1);
      run_pass(0, 1, -1);
    end

    // N=4 sweep of the directed bodies, with a start pulse while busy.
    poke(1, 0, mk_body(100, -50, 64, -128, 7));
    poke(1, 400, mk_force(640, -64));
    poke(1, 1, mk_body(32760, 0, 32700, 0, 3));
    poke(1, 401, mk_force(6400, 0));
    poke(1, 2, mk_body(-32768, 0, -32768, 0, 9));
    poke(1, 402, mk_force(int'(32'h8000_0000), 0));
    poke(1, 3, mk_body(1234, -4321, 63, -64, 11));
    poke(1, 403, mk_force(0, 0));
    run_pass(1, 4, 8);

    // Start from DONE with fresh random contents.
    load_random(1, 4);
    run_pass(1, 4, -1);

    // Reset during the WRITE of body 2.
    load_random(1, 4);
    exp0  = model_step(mem[1][0], mem[1][400]);
    exp1  = model_step(mem[1][1], mem[1][401]);
    orig2 = mem[1][2];
    orig3 = mem[1][3];
    start[1] = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick;
      if (c == 1) start[1] = 1'b0;
    end
    check_val("wr_before_rst", {wr_en[1], addr[1]}, {1'b1, 16'd2});
    reset = 1'b1;
    #1;
    check_val("wr_gated", 80'(wr_en[1]), 80'd0);
    tick;
    reset = 1'b0;
    check_val("post_rst_flags", {busy[1], done[1], rd_en[1], wr_en[1]}, 4'b0000);
    tick; tick;
    check_val("rst_body0", mem[1][0], exp0);
    check_val("rst_body1", mem[1][1], exp1);
    check_val("rst_body2", mem[1][2], orig2);
    check_val("rst_body3", mem[1][3], orig3);
    $display("reset_mid_write dut=1 body2=%h", mem[1][2]);
    run_pass(1, 4, -1);

    for (int r = 0; r < 2; r++) begin
      load_random(1, 4);
      run_pass(1, 4, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
